// File: rtl/hook_probe_arbiter.sv
// Round-robin arbiter sharing the item-map RAM between two rope-tip probes.
// Each probe maps pixel coordinates to a grid cell and reads it. A claim probe also clears a non-empty cell.
module hook_probe_arbiter #(
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int CELL_SHIFT = 4,
  parameter int RAM_LAT    = 1,
  parameter int ADDR_W     = 9,
  parameter int ITEM_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              p1_req,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic              p1_claim,
  output logic              p1_ack,
  output logic [ITEM_W-1:0] p1_item,
  input  logic              p2_req,
  input  logic [9:0]        p2_x,
  input  logic [9:0]        p2_y,
  input  logic              p2_claim,
  output logic              p2_ack,
  output logic [ITEM_W-1:0] p2_item,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ITEM_W-1:0] mem_wdata,
  input  logic [ITEM_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  logic [1:0]        state;
  logic              rr_last;
  logic              winner;
  logic              claim_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ITEM_W-1:0] item_q;
  logic [1:0]        wait_cnt;

  logic              any_req;
  logic              grant_sel;
  logic [9:0]        sel_x;
  logic [9:0]        sel_y;
  logic              sel_claim;
  logic [31:0]       col;
  logic [31:0]       row;
  logic              in_range;
  logic [ADDR_W-1:0] cell_addr;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_req   = p1_req | p2_req;
    grant_sel = (p1_req && p2_req) ? ~rr_last : p2_req;
    sel_x     = grant_sel ? p2_x : p1_x;
    sel_y     = grant_sel ? p2_y : p1_y;
    sel_claim = grant_sel ? p2_claim : p1_claim;
    col       = 32'(sel_x >> CELL_SHIFT);
    row       = 32'(sel_y >> CELL_SHIFT);
    in_range  = (col < 32'(COLS)) && (row < 32'(ROWS));
    cell_addr = ADDR_W'(row * 32'(COLS) + col);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= P2;
      winner   <= P1;
      claim_q  <= 1'b0;
      addr_q   <= '0;
      item_q   <= '0;
      wait_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_req) begin
            winner  <= grant_sel;
            rr_last <= grant_sel;
            claim_q <= sel_claim;
            item_q  <= '0;
            // Off-grid probes skip the RAM and answer "empty".
            if (in_range) begin
              addr_q <= cell_addr;
              state  <= READ;
            end else begin
              addr_q <= '0;
              state  <= RESP;
            end
          end
        end
        READ: begin
          wait_cnt <= 2'(RAM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd1) begin
            item_q <= mem_rdata;
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The clearing write shares the ack cycle, so no other port can see the item in between.
  always_comb begin
    busy      = (state != IDLE);
    mem_rd_en = (state == READ);
    mem_addr  = busy ? addr_q : '0;
    mem_wr_en = (state == RESP) && claim_q && (item_q != '0);
    mem_wdata = '0;
    p1_ack    = (state == RESP) && (winner == P1);
    p2_ack    = (state == RESP) && (winner == P2);
    p1_item   = p1_ack ? item_q : '0;
    p2_item   = p2_ack ? item_q : '0;
  end

endmodule
